// File: rtl/particle_ctl.sv
// Single-particle ballistic controller for the VGA overlay: launch, per-frame
// motion with gravity, wall clamping, ceiling and ground handling, landed hold.
module particle_ctl #(
    parameter logic [11:0] GROUND_Y    = 12'd536,
    parameter logic [11:0] X_MAX       = 12'd960,
    parameter logic [3:0]  GRAVITY     = 4'd1,
    parameter logic [3:0]  HOLD_FRAMES = 4'd2
) (
    input  logic        clk60MHz,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        launch,
    input  logic [11:0] xpos_start,
    input  logic [11:0] ypos_start,
    input  logic [3:0]  speed,
    input  logic        dir,
    input  logic [5:0]  vy_init,
    output logic [11:0] xpos_particle,
    output logic [11:0] ypos_particle,
    output logic        active,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, FLY, LANDED} state_t;

    localparam logic [11:0] PARK = 12'hFFF;

    state_t             state, state_nxt;
    logic               vblnk_d;
    logic               tick;
    logic [11:0]        x_nxt, y_nxt;
    logic signed [7:0]  vy, vy_nxt;
    logic [3:0]         hold_cnt, hold_nxt;
    logic [3:0]         speed_r, speed_nxt;
    logic               dir_r, dir_nxt;
    logic               active_nxt, done_nxt;
    logic [12:0]        x_sum, y_sum;
    logic signed [8:0]  vy_sum;

    assign tick = vblnk & ~vblnk_d;

    // 13-bit sums: bit 12 set means the result went negative
    always_comb begin
        x_sum  = dir_r ? ({1'b0, xpos_particle} + {9'd0, speed_r})
                       : ({1'b0, xpos_particle} - {9'd0, speed_r});
        y_sum  = {1'b0, ypos_particle} + {{5{vy[7]}}, vy};
        vy_sum = {vy[7], vy} + $signed({5'd0, GRAVITY});
    end

    always_comb begin
        state_nxt  = state;
        x_nxt      = xpos_particle;
        y_nxt      = ypos_particle;
        vy_nxt     = vy;
        hold_nxt   = hold_cnt;
        speed_nxt  = speed_r;
        dir_nxt    = dir_r;
        active_nxt = active;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                x_nxt      = PARK;
                y_nxt      = PARK;
                vy_nxt     = 8'sd0;
                hold_nxt   = 4'd0;
                active_nxt = 1'b0;
                if (launch) begin
                    x_nxt      = xpos_start;
                    y_nxt      = ypos_start;
                    vy_nxt     = 8'sd0 - $signed({2'b00, vy_init});
                    speed_nxt  = speed;
                    dir_nxt    = dir;
                    active_nxt = 1'b1;
                    state_nxt  = FLY;
                end
            end
            FLY: begin
                if (tick) begin
                    if (x_sum[12])
                        x_nxt = 12'd0;
                    else if (x_sum[11:0] > X_MAX)
                        x_nxt = X_MAX;
                    else
                        x_nxt = x_sum[11:0];

                    vy_nxt = (vy_sum > 9'sd31) ? 8'sd31 : vy_sum[7:0];

                    if (y_sum[12]) begin
                        y_nxt  = 12'd0;
                        vy_nxt = 8'sd0;
                    end else if (y_sum[11:0] >= GROUND_Y) begin
                        y_nxt     = GROUND_Y;
                        vy_nxt    = 8'sd0;
                        hold_nxt  = 4'd0;
                        state_nxt = LANDED;
                    end else begin
                        y_nxt = y_sum[11:0];
                    end
                end
            end
            LANDED: begin
                if (tick) begin
                    hold_nxt = hold_cnt + 4'd1;
                    if (hold_cnt + 4'd1 == HOLD_FRAMES) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state         <= IDLE;
            vblnk_d       <= 1'b0;
            xpos_particle <= PARK;
            ypos_particle <= PARK;
            vy            <= 8'sd0;
            hold_cnt      <= 4'd0;
            speed_r       <= 4'd0;
            dir_r         <= 1'b0;
            active        <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            vblnk_d       <= vblnk;
            xpos_particle <= x_nxt;
            ypos_particle <= y_nxt;
            vy            <= vy_nxt;
            hold_cnt      <= hold_nxt;
            speed_r       <= speed_nxt;
            dir_r         <= dir_nxt;
            active        <= active_nxt;
            done          <= done_nxt;
        end
    end

endmodule

// File: tb/tb_particle_ctl.sv
// Directed bench for particle_ctl: a table of step/expect records plus a
// gravity-saturation sequence.
module tb_particle_ctl;

    localparam logic [11:0] PARK = 12'hFFF;
    localparam int OP_TICK = 0, OP_LAUNCH = 1, OP_RESET = 2, OP_WAIT = 3, OP_LTICK = 4;

    logic        clk60MHz = 1'b0;
    logic        rst = 1'b1;
    logic        vblnk = 1'b0;
    logic        launch = 1'b0;
    logic [11:0] xpos_start = 12'd0;
    logic [11:0] ypos_start = 12'd0;
    logic [3:0]  speed = 4'd0;
    logic        dir = 1'b0;
    logic [5:0]  vy_init = 6'd0;
    logic [11:0] xpos_particle, ypos_particle;
    logic        active, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          op;
        logic [11:0] xs, ys;
        logic [3:0]  sp;
        logic        dr;
        logic [5:0]  vyi;
        logic [11:0] ex, ey;
        logic        ea, ed;
    } vec_t;

    vec_t vecs[$];

    particle_ctl dut (
        .clk60MHz      (clk60MHz),
        .rst           (rst),
        .vblnk         (vblnk),
        .launch        (launch),
        .xpos_start    (xpos_start),
        .ypos_start    (ypos_start),
        .speed         (speed),
        .dir           (dir),
        .vy_init       (vy_init),
        .xpos_particle (xpos_particle),
        .ypos_particle (ypos_particle),
        .active        (active),
        .done          (done)
    );

    always #8 clk60MHz = ~clk60MHz;

    // Each op ends on a falling edge, so outputs are sampled mid-cycle.
    task automatic do_op(input int op, input logic [11:0] xs, input logic [11:0] ys,
                         input logic [3:0] sp, input logic dr, input logic [5:0] vyi);
        case (op)
            OP_TICK: begin
                @(negedge clk60MHz) vblnk = 1'b1;
                @(negedge clk60MHz) vblnk = 1'b0;
            end
            OP_LAUNCH, OP_LTICK: begin
                @(negedge clk60MHz);
                xpos_start = xs; ypos_start = ys; speed = sp; dir = dr; vy_init = vyi;
                launch = 1'b1;
                if (op == OP_LTICK) vblnk = 1'b1;
                @(negedge clk60MHz);
                launch = 1'b0;
                vblnk  = 1'b0;
                // scramble the start inputs; the flight must not follow them
                xpos_start = ~xs; ypos_start = ~ys; speed = ~sp; dir = ~dr; vy_init = ~vyi;
            end
            OP_RESET: begin
                @(negedge clk60MHz) rst = 1'b1;
                @(negedge clk60MHz) rst = 1'b0;
            end
            default: @(negedge clk60MHz);
        endcase
    endtask

    task automatic check(input string name, input logic [11:0] ex, input logic [11:0] ey,
                         input logic ea, input logic ed);
        checks++;
        if (xpos_particle !== ex || ypos_particle !== ey || active !== ea || done !== ed) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d active=%0b done=%0b, expected x=%0d y=%0d active=%0b done=%0b",
                     name, xpos_particle, ypos_particle, active, done, ex, ey, ea, ed);
        end
    endtask

    function automatic vec_t mk(int op, int xs, int ys, int sp, int dr, int vyi,
                                int ex, int ey, int ea, int ed);
        vec_t v;
        v.op = op; v.xs = 12'(xs); v.ys = 12'(ys); v.sp = 4'(sp); v.dr = 1'(dr);
        v.vyi = 6'(vyi); v.ex = 12'(ex); v.ey = 12'(ey); v.ea = 1'(ea); v.ed = 1'(ed);
        return v;
    endfunction

    initial begin
        // arc
        vecs.push_back(mk(OP_LAUNCH, 100, 500, 4, 1, 3, 100, 500, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 104, 497, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 108, 495, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 112, 494, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 116, 494, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 120, 495, 1, 0));
        vecs.push_back(mk(OP_WAIT,   0, 0, 0, 0, 0, 120, 495, 1, 0));
        vecs.push_back(mk(OP_RESET,  0, 0, 0, 0, 0, PARK, PARK, 0, 0));
        // right wall
        vecs.push_back(mk(OP_LAUNCH, 950, 500, 15, 1, 0, 950, 500, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 960, 500, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 960, 501, 1, 0));
        vecs.push_back(mk(OP_RESET,  0, 0, 0, 0, 0, PARK, PARK, 0, 0));
        // left wall
        vecs.push_back(mk(OP_LAUNCH, 5, 300, 8, 0, 0, 5, 300, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 0, 300, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 0, 301, 1, 0));
        vecs.push_back(mk(OP_RESET,  0, 0, 0, 0, 0, PARK, PARK, 0, 0));
        // landing, hold, done, park
        vecs.push_back(mk(OP_LAUNCH, 200, 530, 0, 1, 0, 200, 530, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 200, 530, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 200, 531, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 200, 533, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 200, 536, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 200, 536, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 200, 536, 1, 1));
        vecs.push_back(mk(OP_WAIT,   0, 0, 0, 0, 0, PARK, PARK, 0, 0));
        vecs.push_back(mk(OP_WAIT,   0, 0, 0, 0, 0, PARK, PARK, 0, 0));
        // ceiling
        vecs.push_back(mk(OP_LAUNCH, 50, 2, 0, 1, 10, 50, 2, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 50, 0, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 50, 0, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 50, 1, 1, 0));
        vecs.push_back(mk(OP_RESET,  0, 0, 0, 0, 0, PARK, PARK, 0, 0));
        // relaunch in flight is ignored
        vecs.push_back(mk(OP_LAUNCH, 100, 500, 4, 1, 3, 100, 500, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 104, 497, 1, 0));
        vecs.push_back(mk(OP_LAUNCH, 10, 10, 1, 0, 0, 104, 497, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 108, 495, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 112, 494, 1, 0));
        vecs.push_back(mk(OP_RESET,  0, 0, 0, 0, 0, PARK, PARK, 0, 0));
        // launch coinciding with a tick only loads
        vecs.push_back(mk(OP_LTICK,  300, 400, 2, 1, 0, 300, 400, 1, 0));
        vecs.push_back(mk(OP_WAIT,   0, 0, 0, 0, 0, 300, 400, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 302, 400, 1, 0));
        // reset mid-flight, then the arc again
        vecs.push_back(mk(OP_RESET,  0, 0, 0, 0, 0, PARK, PARK, 0, 0));
        vecs.push_back(mk(OP_LAUNCH, 100, 500, 4, 1, 3, 100, 500, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 104, 497, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 108, 495, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 112, 494, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 116, 494, 1, 0));
        vecs.push_back(mk(OP_TICK,   0, 0, 0, 0, 0, 120, 495, 1, 0));
        vecs.push_back(mk(OP_RESET,  0, 0, 0, 0, 0, PARK, PARK, 0, 0));

        repeat (3) @(negedge clk60MHz);
        rst = 1'b0;
        check("reset", PARK, PARK, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].op, vecs[i].xs, vecs[i].ys, vecs[i].sp, vecs[i].dr, vecs[i].vyi);
            check($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ea, vecs[i].ed);
        end

        // free fall from y=0: y = k(k-1)/2 until vy saturates at 31 after tick 31
        do_op(OP_LAUNCH, 12'd0, 12'd0, 4'd0, 1'b1, 6'd0);
        check("sat_launch", 12'd0, 12'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 31; k++) do_op(OP_TICK, 0, 0, 0, 0, 0);
        check("sat_t31", 12'd0, 12'd465, 1'b1, 1'b0);
        do_op(OP_TICK, 0, 0, 0, 0, 0);
        check("sat_t32", 12'd0, 12'd496, 1'b1, 1'b0);
        do_op(OP_TICK, 0, 0, 0, 0, 0);
        check("sat_t33", 12'd0, 12'd527, 1'b1, 1'b0);
        do_op(OP_TICK, 0, 0, 0, 0, 0);
        check("sat_land", 12'd0, 12'd536, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/particle_ctl.md
PARTICLE_CTL -- requirements
Module: particle_ctl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- GROUND_Y, 12'd536, landing line for ypos_particle.
- X_MAX, 12'd960, rightmost allowed xpos_particle.
- GRAVITY, 4'd1, added to the vertical velocity every frame tick.
- HOLD_FRAMES, 4'd2, frames spent in LANDED; legal range is 1 or more.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk60MHz, in, 1, the single clock.
- rst, in, 1, synchronous, active-high reset.
- vblnk, in, 1, VGA vertical blank; its rising edge is the frame tick.
- launch, in, 1, single-cycle start request.
- xpos_start, in, 12, launch x.
- ypos_start, in, 12, launch y.
- speed, in, 4, horizontal step per frame, in pixels.
- dir, in, 1, 1 = move right, 0 = move left.
- vy_init, in, 6, initial upward speed, in pixels per frame.
- xpos_particle, out, 12, particle x for the overlay drawer.
- ypos_particle, out, 12, particle y for the overlay drawer.
- active, out, 1, particle is in flight or landed.
- done, out, 1, one-cycle pulse at the end of the sequence.

Function
REQ-003 The block SHALL register vblnk into vblnk_d, and the frame tick SHALL equal vblnk AND NOT vblnk_d.
REQ-004 The state machine SHALL have three states: IDLE, FLY and LANDED.
REQ-005 In IDLE, xpos_particle and ypos_particle SHALL both be 12'hFFF (park value, never drawn), and active SHALL be 0.
REQ-006 When launch=1 in IDLE, on the next clock the block SHALL:
- load x=xpos_start and y=ypos_start;
- load vy = -vy_init (signed, 8 bit);
- enter FLY;
- set active=1.
REQ-007 A launch that coincides with a tick in IDLE SHALL only load; the first movement SHALL happen on the next tick.
REQ-008 When launch=1 in FLY or LANDED, the block SHALL ignore it.
REQ-009 On each tick in FLY, the block SHALL update, registered, with outputs visible the next clock:
- y_new = y + vy, computed 13-bit signed;
- vy_new = vy + GRAVITY, saturating at +31;
- x_new = x + speed if dir=1, else x - speed, computed 13-bit signed.
REQ-010 The block SHALL clamp x_new to the range 0 to X_MAX; a clamped x SHALL stay at the bound while vertical motion continues.
REQ-011 If y_new < 0, the block SHALL set y=0 and vy=0 (ceiling).
REQ-012 If y_new >= GROUND_Y, the block SHALL set y=GROUND_Y, vy=0, clear the hold counter and enter LANDED in the same update.
REQ-013 In LANDED, x and y SHALL hold, and each tick SHALL increment the hold counter.
REQ-014 On the tick where the hold counter reaches HOLD_FRAMES, the block SHALL:
- go to IDLE;
- pulse done=1 for exactly one clock;
- park both outputs on the next clock.
REQ-015 Between ticks, all state and outputs SHALL hold.
REQ-016 Changes to xpos_start, ypos_start, speed, dir or vy_init after launch SHALL have no effect until the next launch.

Reset
REQ-017 When rst=1 at a clock edge, the block SHALL set:
- state = IDLE;
- xpos_particle = ypos_particle = 12'hFFF;
- vy = 0, hold counter = 0, vblnk_d = 0;
- active = 0, done = 0.
REQ-018 A reset asserted mid-flight SHALL abort the flight without producing a done pulse.
REQ-019 The first tick after reset SHALL be detected only on a vblnk edge that occurs after reset is released.

Verification
REQ-020 Arc: launch with x=100, y=500, speed=4, dir=1, vy_init=3. Over ticks 1 to 5, y SHALL read 497, 495, 494, 494, 495, and x SHALL read 104, 108, 112, 116, 120.
REQ-021 Wall clamp:
- x=950, dir=1, speed=15 -> x=960 on tick 1 and 960 on tick 2.
- x=5, dir=0, speed=8 -> x=0 on tick 1.
REQ-022 Landing: y=530, vy_init=0, HOLD_FRAMES=2.
- y SHALL read 530, 531, 533, 536 over ticks 1 to 4; LANDED is entered at tick 4.
- On tick 6, done SHALL pulse once.
- One clock later, the outputs SHALL read 12'hFFF and active SHALL be 0.
REQ-023 Ceiling: y=2, vy_init=10 -> tick 1 gives y=0 and vy=0; tick 2 gives y=0; tick 3 gives y=1.
REQ-024 Launch during FLY with different start values -> the trajectory SHALL be unchanged. Launch on the same cycle as a tick in IDLE -> outputs SHALL equal the start values until the next tick.
REQ-025 rst pulsed during FLY -> on the next clock, outputs SHALL be 12'hFFF, active=0 and done=0. A new launch afterwards SHALL reproduce the REQ-020 sequence.
